counter_cmd_seq: RTL and testbench
==================================

# counter_cmd_seq

Command sequencer that drives the control inputs of the 16-bit up/down load counter. It also runs a cycle-accurate reference model of the counter and flags any divergence from the counter's `data_out`. It sits between a testbench or host command source (valid/ready) and the counter. It translates LOAD/UP/DOWN/HOLD commands into the counter's pin-level protocol: `ld_cnt` active-low, `count_enb` active-high, `updn_cnt` 1=up.

## Interface
- `WIDTH`, 16, counter data width
- `LEN_W`, 8, width of the command repeat-length field
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  sequencer can accept a command this cycle
- `cmd_op`  in  2  00 HOLD, 01 LOAD, 10 UP, 11 DOWN
- `cmd_data`  in  WIDTH  load value (LOAD only)
- `cmd_len`  in  LEN_W  repeat count minus one (HOLD/UP/DOWN); ignored for LOAD
- `ld_cnt`  out  1  to counter, active-low load
- `count_enb`  out  1  to counter, count enable
- `updn_cnt`  out  1  to counter, 1=up, 0=down
- `data_in`  out  WIDTH  to counter, load value
- `data_out`  in  WIDTH  from counter
- `busy`  out  1  command executing
- `expected`  out  WIDTH  model value of counter output
- `mismatch`  out  1  sticky compare-failure flag
- `err_cnt`  out  8  saturating compare-failure count

## Operation
- FSM states: IDLE, RUN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, capture op/data/len, load the remaining counter with len (0 for LOAD), and go to RUN.
- RUN: drive controls per captured op and decrement remaining each cycle.
  - HOLD: `ld_cnt`=1, `count_enb`=0.
  - LOAD: `ld_cnt`=0, `count_enb`=1, `data_in`=cmd_data. `count_enb` is forced to 1 because load with enable low is an illegal counter input.
  - UP: `ld_cnt`=1, `count_enb`=1, `updn_cnt`=1.
  - DOWN: `ld_cnt`=1, `count_enb`=1, `updn_cnt`=0.
- `cmd_ready` = IDLE, or RUN with remaining==0, and is always 0 while `rst`=0.
- Acceptance in the last RUN cycle reloads RUN with the new command, with no bubble. Otherwise the FSM returns to IDLE when remaining==0.
- Idle control values: `ld_cnt`=1, `count_enb`=0, `updn_cnt`=1, `data_in`=0. `data_in` holds 0 except during LOAD.
- `busy` = (state==RUN).
- Reference model, registered, driven from the registered control outputs:
  - If `ld_cnt`=0: `expected` <= `data_in`.
  - Else if `count_enb`=1: `expected` <= `expected`±1, modulo 2^WIDTH (0xFFFF+1=0x0000, 0x0000−1=0xFFFF).
  - Else: hold.
- Compare every cycle with `rst`=1.
  - If `data_out` != `expected`, set `mismatch` at the next edge and increment `err_cnt`.
  - `err_cnt` saturates at 255.
  - `mismatch` clears only on reset.
- Reset mid-command aborts it: no residual control pulses. The counter also resets to 0, so the model stays aligned.

## Timing
- Reset values: state IDLE, `ld_cnt`=1, `count_enb`=0, `updn_cnt`=1, `data_in`=0, `busy`=0, `expected`=0, `mismatch`=0, `err_cnt`=0, remaining=0.
- Command accepted at edge N: control outputs reflect it from edge N to edge N+len+1, i.e. len+1 cycles, with LOAD exactly 1 cycle.
- Counter `data_out` and `expected` show the first effect after edge N+1.
- Compare latency: a divergence visible in cycle K sets `mismatch` after edge K+1.
- All outputs are registered except `cmd_ready` (combinational from state/remaining/rst).

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `cmd_valid`=1 → `cmd_ready`=0, every output at its reset value, no command accepted.
- LOAD 0x1234, then UP len=3 → `data_out`/`expected` = 0x1234, 0x1235, 0x1236, 0x1237, 0x1238 on consecutive cycles, `mismatch`=0, `busy` low after the last count.
- LOAD 0x0001, then DOWN len=2 → 0x0001, 0x0000, 0xFFFF, 0xFFFE (wrap), `mismatch`=0.
- HOLD len=4 after LOAD 0xA5A5 → `count_enb`=0 for 5 cycles and `data_out` stable at 0xA5A5. Back-to-back UP len=0 with `cmd_valid` held high → no idle cycle between commands, giving 0xA5A6 on the next cycle.
- Fault injection: force `data_out` to `expected`^1 for 2 cycles → `mismatch`=1 one cycle later and stays 1, `err_cnt`=2. Reset clears both.
- Reset mid-UP (len=200, assert `rst`=0 at the 10th count) → next cycle `count_enb`=0, `busy`=0, `expected`=0. After release, a new LOAD is accepted normally.

Source files
------------

// File: rtl/counter_cmd_seq_if.sv
// Command handshake bundle between a host command source and counter_cmd_seq.
// Carries cmd_valid/cmd_ready plus the op, load data and repeat length fields.
interface counter_cmd_seq_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [LEN_W-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/counter_cmd_seq.sv
// Command sequencer for the up/down load counter, with a registered reference
// model of the counter and a sticky compare-failure flag / saturating count.
// Ports: clk, rst (sync, active-low), cmd (slave command handshake),
// ld_cnt/count_enb/updn_cnt/data_in (to counter), data_out (from counter),
// busy, expected, mismatch, err_cnt.
module counter_cmd_seq #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    counter_cmd_seq_if.slave cmd,
    output logic             ld_cnt,
    output logic             count_enb,
    output logic             updn_cnt,
    output logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic [7:0]       err_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    state_t           state, state_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic             ld_n, en_n, ud_n;
    logic [WIDTH-1:0] din_n;
    logic             accept;

    // Ready in IDLE or in the last RUN cycle, so commands chain without a bubble.
    assign cmd.cmd_ready = rst && (state == IDLE || rem == '0);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        state_n = state;
        rem_n   = rem;
        ld_n    = ld_cnt;
        en_n    = count_enb;
        ud_n    = updn_cnt;
        din_n   = data_in;
        if (accept) begin
            state_n = RUN;
            rem_n   = cmd.cmd_len;
            ld_n    = 1'b1;
            en_n    = 1'b1;
            ud_n    = 1'b1;
            din_n   = '0;
            unique case (cmd.cmd_op)
                OP_HOLD: en_n = 1'b0;
                OP_LOAD: begin
                    // Enable stays high: load with enable low is illegal.
                    ld_n  = 1'b0;
                    din_n = cmd.cmd_data;
                    rem_n = '0;
                end
                OP_UP:   ud_n = 1'b1;
                OP_DOWN: ud_n = 1'b0;
            endcase
        end else if (state == RUN) begin
            if (rem == '0) begin
                state_n = IDLE;
                ld_n    = 1'b1;
                en_n    = 1'b0;
                ud_n    = 1'b1;
                din_n   = '0;
            end else begin
                rem_n = rem - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rem       <= '0;
            ld_cnt    <= 1'b1;
            count_enb <= 1'b0;
            updn_cnt  <= 1'b1;
            data_in   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            rem       <= rem_n;
            ld_cnt    <= ld_n;
            count_enb <= en_n;
            updn_cnt  <= ud_n;
            data_in   <= din_n;
            busy      <= (state_n == RUN);
        end
    end

    // Reference model follows the registered pins, exactly as the counter sees them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            expected <= '0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (!ld_cnt) begin
                expected <= data_in;
            end else if (count_enb) begin
                expected <= updn_cnt ? expected + WIDTH'(1)
                                     : expected - WIDTH'(1);
            end
            if (data_out != expected) begin
                mismatch <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq with a behavioural 16-bit counter.
// Checks reset, load/up/down/hold sequencing, wrap, chaining, faults, abort.
module tb_counter_cmd_seq;

    localparam int WIDTH = 16;
    localparam int LEN_W = 8;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] UP   = 2'b10;
    localparam logic [1:0] DOWN = 2'b11;

    logic             clk;
    logic             rst;
    logic             ld_cnt, count_enb, updn_cnt, busy, mismatch;
    logic [WIDTH-1:0] data_in, data_out, expected;
    logic [7:0]       err_cnt;
    logic [WIDTH-1:0] cnt;
    logic             fault;

    int n_chk;
    int n_pass;

    counter_cmd_seq_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) cif ();

    counter_cmd_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cif),
        .ld_cnt    (ld_cnt),
        .count_enb (count_enb),
        .updn_cnt  (updn_cnt),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .expected  (expected),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural counter driven by the sequencer pins.
    always @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (!ld_cnt)
            cnt <= data_in;
        else if (count_enb)
            cnt <= updn_cnt ? cnt + 16'd1 : cnt - 16'd1;
    end

    assign data_out = fault ? (cnt ^ 16'h0001) : cnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present a command at the next negedge and hold it until accepted.
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d,
                         input logic [LEN_W-1:0] len);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = d;
        cif.cmd_len   = len;
        for (int i = 0; i < 300; i++) begin
            if (cif.cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic see(input string tag, input logic [WIDTH-1:0] v);
        chk({tag, "_dout"}, 32'(data_out), 32'(v));
        chk({tag, "_exp"}, 32'(expected), 32'(v));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        fault = 1'b0;
        rst = 1'b0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = LOAD;
        cif.cmd_data  = 16'hBEEF;
        cif.cmd_len   = 8'd0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(cif.cmd_ready), 32'd0);
        end
        chk("rst_ld", 32'(ld_cnt), 32'd1);
        chk("rst_en", 32'(count_enb), 32'd0);
        chk("rst_ud", 32'(updn_cnt), 32'd1);
        chk("rst_din", 32'(data_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_exp", 32'(expected), 32'd0);
        chk("rst_mis", 32'(mismatch), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        rst = 1'b1;
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cif.cmd_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // LOAD 0x1234 then UP len=3
        issue(LOAD, 16'h1234, 8'd0);
        issue(UP, 16'h0000, 8'd3);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        see("up0", 16'h1234);
        chk("up_en", 32'(count_enb), 32'd1);
        @(negedge clk); see("up1", 16'h1235);
        @(negedge clk); see("up2", 16'h1236);
        @(negedge clk); see("up3", 16'h1237);
        @(negedge clk); see("up4", 16'h1238);
        chk("up_busy", 32'(busy), 32'd0);
        chk("up_mis", 32'(mismatch), 32'd0);

        // LOAD 0x0001 then DOWN len=2 with wrap
        issue(LOAD, 16'h0001, 8'd0);
        issue(DOWN, 16'h0000, 8'd2);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        see("dn0", 16'h0001);
        chk("dn_ud", 32'(updn_cnt), 32'd0);
        @(negedge clk); see("dn1", 16'h0000);
        @(negedge clk); see("dn2", 16'hFFFF);
        @(negedge clk); see("dn3", 16'hFFFE);
        chk("dn_mis", 32'(mismatch), 32'd0);

        // LOAD 0xA5A5, HOLD len=4, then UP len=0 chained with valid held
        issue(LOAD, 16'hA5A5, 8'd0);
        issue(HOLD, 16'h0000, 8'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cif.cmd_valid = 1'b1;
                cif.cmd_op    = UP;
                cif.cmd_len   = 8'd0;
            end
            chk("hold_en", 32'(count_enb), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_dout", 32'(data_out), 32'hA5A5);
            chk("hold_ready", 32'(cif.cmd_ready), (i == 4) ? 32'd1 : 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("chain_en", 32'(count_enb), 32'd1);
        chk("chain_busy", 32'(busy), 32'd1);
        see("chain0", 16'hA5A5);
        @(negedge clk);
        see("chain1", 16'hA5A6);
        chk("chain_idle", 32'(busy), 32'd0);

        // Fault injection for two cycles
        fault = 1'b1;
        @(negedge clk);
        chk("flt_mis1", 32'(mismatch), 32'd1);
        chk("flt_err1", 32'(err_cnt), 32'd1);
        @(negedge clk);
        fault = 1'b0;
        chk("flt_err2", 32'(err_cnt), 32'd2);
        repeat (3) @(negedge clk);
        chk("flt_mis_sticky", 32'(mismatch), 32'd1);
        chk("flt_err_hold", 32'(err_cnt), 32'd2);
        rst = 1'b0;
        @(negedge clk);
        chk("flt_rst_mis", 32'(mismatch), 32'd0);
        chk("flt_rst_err", 32'(err_cnt), 32'd0);
        chk("flt_rst_exp", 32'(expected), 32'd0);
        rst = 1'b1;

        // Reset in the middle of a long UP
        issue(UP, 16'h0000, 8'd200);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        see("abort_pre", 16'd10);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_en", 32'(count_enb), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_exp", 32'(expected), 32'd0);
        chk("abort_ready", 32'(cif.cmd_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        see("abort_idle", 16'h0000);
        issue(LOAD, 16'h00FF, 8'd0);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("reload_ld", 32'(ld_cnt), 32'd0);
        chk("reload_din", 32'(data_in), 32'h00FF);
        @(negedge clk);
        see("reload", 16'h00FF);
        chk("reload_ldoff", 32'(ld_cnt), 32'd1);
        chk("final_mis", 32'(mismatch), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
